// File: rtl/tcdm_multiport_model.sv
// Behavioural multi-port TCDM for simulation benches: zero-wait grants, one-cycle responses,
// byte-addressed little-endian storage reachable as "memory" for hierarchical preload.
module tcdm_multiport_model #(
   parameter int unsigned MP          = 1,
   parameter logic [31:0] MEMORY_SIZE = 32'h30000,
   parameter logic [31:0] BASE_ADDR   = 32'h0
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 enable_i,
   input  logic [MP-1:0]        tcdm_req_i,
   input  logic [MP-1:0][31:0]  tcdm_add_i,
   input  logic [MP-1:0]        tcdm_wen_i,
   input  logic [MP-1:0][3:0]   tcdm_be_i,
   input  logic [MP-1:0][31:0]  tcdm_data_i,
   output logic [MP-1:0]        tcdm_gnt_o,
   output logic [MP-1:0][31:0]  tcdm_r_data_o,
   output logic [MP-1:0]        tcdm_r_valid_o
);

   localparam int unsigned AW = $clog2(MEMORY_SIZE);

   logic [7:0] memory [MEMORY_SIZE];

   logic [MP-1:0]          w_xact;
   logic [MP-1:0][AW-1:0]  w_idx;
   logic [MP-1:0]          r_valid;
   logic [MP-1:0][31:0]    r_rdata;

   assign tcdm_gnt_o = tcdm_req_i & {MP{enable_i}};
   assign w_xact     = tcdm_req_i & tcdm_gnt_o;

   // Out-of-window addresses wrap modulo the storage size.
   always_comb begin
      w_idx = '0;
      for (int p = 0; p < int'(MP); p++) begin
         w_idx[p] = AW'(((tcdm_add_i[p] & ~32'h3) - BASE_ADDR) % MEMORY_SIZE);
      end
   end

   // Ascending port loop: the highest port index wins a same-byte collision.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         for (int p = 0; p < int'(MP); p++) begin
            for (int b = 0; b < 4; b++) begin
               if (w_xact[p] && !tcdm_wen_i[p] && tcdm_be_i[p][b]) begin
                  memory[w_idx[p] + AW'(b)] <= tcdm_data_i[p][8*b +: 8];
               end
            end
         end
      end
   end

   // Storage is sampled before this edge's writes land, so both reads and writes
   // return the old word.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_valid <= '0;
         r_rdata <= '0;
      end else begin
         for (int p = 0; p < int'(MP); p++) begin
            r_valid[p] <= w_xact[p];
            if (w_xact[p]) begin
               r_rdata[p] <= {memory[w_idx[p] + AW'(3)], memory[w_idx[p] + AW'(2)],
                              memory[w_idx[p] + AW'(1)], memory[w_idx[p]]};
            end
         end
      end
   end

   assign tcdm_r_valid_o = r_valid;
   assign tcdm_r_data_o  = r_rdata;

endmodule

// File: tb/tb_tcdm_multiport_model.sv
// Directed bench for tcdm_multiport_model with three ports: grant/response timing,
// byte enables, same-edge collisions, enable gating, address wrap and reset behaviour.
module tb_tcdm_multiport_model;

   localparam int unsigned MP = 3;

   logic                clk;
   logic                rst;
   logic                enable;
   logic [MP-1:0]       req;
   logic [MP-1:0][31:0] add;
   logic [MP-1:0]       wen;
   logic [MP-1:0][3:0]  be;
   logic [MP-1:0][31:0] wdata;
   logic [MP-1:0]       gnt;
   logic [MP-1:0][31:0] rdata;
   logic [MP-1:0]       rvalid;

   int n_cmp = 0;
   int n_err = 0;

   tcdm_multiport_model #(
      .MP          (MP),
      .MEMORY_SIZE (32'h30000),
      .BASE_ADDR   (32'h0)
   ) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .enable_i       (enable),
      .tcdm_req_i     (req),
      .tcdm_add_i     (add),
      .tcdm_wen_i     (wen),
      .tcdm_be_i      (be),
      .tcdm_data_i    (wdata),
      .tcdm_gnt_o     (gnt),
      .tcdm_r_data_o  (rdata),
      .tcdm_r_valid_o (rvalid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive(input int p, input logic rq, input logic we_n, input logic [31:0] a,
                        input logic [3:0] b, input logic [31:0] d);
      req[p]   = rq;
      wen[p]   = we_n;
      add[p]   = a;
      be[p]    = b;
      wdata[p] = d;
   endtask

   // Advance past the next rising edge and drop all requests.
   task automatic step();
      @(posedge clk);
      #1;
      req = '0;
   endtask

   initial begin
      rst    = 1'b1;
      enable = 1'b1;
      req    = '0;
      add    = '0;
      wen    = '1;
      be     = '0;
      wdata  = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_rvalid", 32'(rvalid), 32'h0);
      check("reset_rdata0", rdata[0], 32'h0);
      rst = 1'b0;
      step();

      // Full-word write then read on port 0.
      drive(0, 1'b1, 1'b0, 32'h8, 4'hF, 32'hDEADBEEF);
      #1 check("wr_gnt", 32'(gnt), 32'h1);
      step();
      check("wr_rvalid", 32'(rvalid), 32'h1);
      drive(0, 1'b1, 1'b1, 32'h8, 4'h0, 32'h0);
      #1 check("rd_gnt", 32'(gnt), 32'h1);
      step();
      check("rd_rvalid", 32'(rvalid), 32'h1);
      check("rd_data", rdata[0], 32'hDEADBEEF);

      // Idle: valid drops, data holds.
      step();
      check("idle_rvalid", 32'(rvalid), 32'h0);
      check("idle_hold", rdata[0], 32'hDEADBEEF);

      // Partial byte enables; write response carries pre-write word.
      drive(0, 1'b1, 1'b0, 32'h8, 4'b0101, 32'h11223344);
      step();
      check("pwr_olddata", rdata[0], 32'hDEADBEEF);
      drive(0, 1'b1, 1'b1, 32'h8, 4'h0, 32'h0);
      step();
      check("pwr_readback", rdata[0], 32'hDE22BE44);

      // Same-edge collision at 0x10.
      drive(0, 1'b1, 1'b0, 32'h10, 4'hF, 32'h0);
      step();
      drive(0, 1'b1, 1'b0, 32'h10, 4'hF, 32'hAAAAAAAA);
      drive(1, 1'b1, 1'b1, 32'h10, 4'h0, 32'h0);
      drive(2, 1'b1, 1'b0, 32'h10, 4'hF, 32'h55555555);
      #1 check("coll_gnt", 32'(gnt), 32'h7);
      step();
      check("coll_rvalid", 32'(rvalid), 32'h7);
      check("coll_p1_old", rdata[1], 32'h0);
      check("coll_p0_old", rdata[0], 32'h0);

      // Back-to-back reads on port 1.
      drive(1, 1'b1, 1'b1, 32'h10, 4'h0, 32'h0);
      @(posedge clk);
      #1;
      check("coll_winner", rdata[1], 32'h55555555);
      drive(1, 1'b1, 1'b1, 32'h8, 4'h0, 32'h0);
      step();
      check("b2b_rvalid", 32'(rvalid), 32'h2);
      check("b2b_data", rdata[1], 32'hDE22BE44);

      // enable_i low blocks grants and writes.
      drive(0, 1'b1, 1'b0, 32'h20, 4'hF, 32'hA5A5A5A5);
      step();
      enable = 1'b0;
      drive(0, 1'b1, 1'b0, 32'h20, 4'hF, 32'h12345678);
      drive(1, 1'b1, 1'b1, 32'h20, 4'h0, 32'h0);
      drive(2, 1'b1, 1'b0, 32'h20, 4'hF, 32'h87654321);
      #1 check("dis_gnt", 32'(gnt), 32'h0);
      step();
      check("dis_rvalid", 32'(rvalid), 32'h0);
      enable = 1'b1;
      drive(2, 1'b1, 1'b1, 32'h20, 4'h0, 32'h0);
      step();
      check("dis_unchanged", rdata[2], 32'hA5A5A5A5);

      // Address wrap: 0x140000 mod 0x30000 = 0x20000.
      drive(0, 1'b1, 1'b0, 32'h00140000, 4'hF, 32'hCAFEF00D);
      step();
      drive(0, 1'b1, 1'b1, 32'h00140000, 4'h0, 32'h0);
      step();
      check("wrap_read", rdata[0], 32'hCAFEF00D);
      check("wrap_b0", 32'(dut.memory[32'h20000]), 32'h0D);
      check("wrap_b1", 32'(dut.memory[32'h20001]), 32'hF0);
      check("wrap_b2", 32'(dut.memory[32'h20002]), 32'hFE);
      check("wrap_b3", 32'(dut.memory[32'h20003]), 32'hCA);
      drive(1, 1'b1, 1'b1, 32'h00020000, 4'h0, 32'h0);
      step();
      check("wrap_alias", rdata[1], 32'hCAFEF00D);

      // Reset right after a granted read; writes under reset are dropped.
      drive(0, 1'b1, 1'b0, 32'h40, 4'hF, 32'h0BADF00D);
      step();
      drive(0, 1'b1, 1'b1, 32'h40, 4'h0, 32'h0);
      step();
      check("pre_rst_rvalid", 32'(rvalid), 32'h1);
      rst = 1'b1;
      #1;
      check("rst_rvalid", 32'(rvalid), 32'h0);
      check("rst_rdata", rdata[0], 32'h0);
      drive(0, 1'b1, 1'b0, 32'h40, 4'hF, 32'hFFFFFFFF);
      #1 check("rst_gnt", 32'(gnt), 32'h1);
      step();
      check("rst_rvalid_hold", 32'(rvalid), 32'h0);
      rst = 1'b0;
      drive(0, 1'b1, 1'b1, 32'h40, 4'h0, 32'h0);
      step();
      check("post_rst_data", rdata[0], 32'h0BADF00D);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/tcdm_multiport_model.md
Name: tcdm_multiport_model

Overview:
- Behavioural multi-port TCDM memory model for simulation benches.
- Each port is an independent 32-bit word interface with req/gnt and r_valid.
- The benches share one instance between the accelerator streamer ports, the core data port and the core instruction port.
- Storage is a byte array preloadable by $readmemh through the hierarchical name "memory".

Parameters:
- MP, 1: number of ports.
- MEMORY_SIZE, 32'h30000: storage size in bytes; must be a multiple of 4.
- BASE_ADDR, 32'h0: byte address mapped to memory[0].

Ports:
- clk_i  in  1  clock; all state updates on its rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- enable_i  in  1  global enable; 0 blocks all grants.
- tcdm_req_i  in  MP  per-port request.
- tcdm_add_i  in  MP x 32  per-port byte address.
- tcdm_wen_i  in  MP  per-port write-enable-bar: 1 = read, 0 = write.
- tcdm_be_i  in  MP x 4  per-port byte enables; bit i covers data[8i+7:8i].
- tcdm_data_i  in  MP x 32  per-port write data.
- tcdm_gnt_o  out  MP  per-port grant.
- tcdm_r_data_o  out  MP x 32  per-port read data.
- tcdm_r_valid_o  out  MP  per-port response valid.

Behaviour:
- Storage: logic [7:0] memory[MEMORY_SIZE], little-endian.
  - Not cleared by reset.
  - Uninitialised bytes read as X in simulation.
- Address map per port:
  - off = ((add & ~3) - BASE_ADDR) mod MEMORY_SIZE, 32-bit unsigned subtraction.
  - Word occupies memory[off..off+3].
  - Addresses outside the window alias (wrap) into it; no error is flagged.
- Grant: tcdm_gnt_o[p] = tcdm_req_i[p] & enable_i. It is combinational, zero wait states, with no arbitration between ports.
- A transaction happens when req & gnt are both high at a rising edge.
- Write (wen=0):
  - At that edge, memory[off+i] <= data[8i+7:8i] for each i with be[i]=1.
  - Bytes with be=0 are untouched.
- Read (wen=1): be is ignored and all 4 bytes are returned.
- Response:
  - r_valid[p] is high exactly one cycle after the granted edge, for both reads and writes.
  - r_data[p] is registered at the granted edge.
  - Read: r_data holds the word contents before any same-edge write.
  - Write: r_data holds the pre-write word contents.
- Idle: when there is no granted request, r_valid falls to 0 and r_data holds its last value.
- Back-to-back: a new request every cycle is accepted; throughput is 1 per port per cycle.
- Simultaneous writes to the same byte from several ports on one edge: the highest port index wins.
- Simultaneous read and write to the same word on one edge: the read returns the old data. The write is visible from the next edge onward.
- enable_i=0: all gnt=0, no memory update, and r_valid=0 on the next cycle.
- Reset:
  - While rst_i=1: r_valid=0, r_data=0, and memory writes are suppressed.
  - gnt still follows req & enable_i combinationally.
  - A response pending when reset asserts is dropped.
  - Memory contents survive reset.
- Ports are fully independent, so any port mix of reads and writes is legal in the same cycle.

Test Plan:
- Reset, then on port 0 write 32'hDEADBEEF to BASE_ADDR+8 with be=4'hF, then read BASE_ADDR+8.
  - Expect gnt in the same cycle as req on both accesses.
  - Expect r_valid one cycle later on both accesses.
  - Expect read data 32'hDEADBEEF.
- Partial byte enables: write 32'h11223344 with be=4'b0101 over 32'hDEADBEEF, then read the word back.
  - Expect 32'hDE22BE44.
- Same-edge access on MP=3, address BASE_ADDR+0x10, prior contents 32'h00000000:
  - Port 0 writes 32'hAAAAAAAA, port 2 writes 32'h55555555, port 1 reads.
  - Port 1 returns 32'h00000000.
  - A later read returns 32'h55555555.
- enable_i=0 with req=1 on all ports.
  - Expect gnt=0 and r_valid=0.
  - Memory is unchanged: a write attempted during this time is absent on a later read.
- Wrap-around with BASE_ADDR=0 and MEMORY_SIZE=32'h30000: write 32'hCAFEF00D to 32'h00140000.
  - A read of 32'h00140000 returns 32'hCAFEF00D.
  - memory[32'h20000..32'h20003] = 0D,F0,FE,CA.
- Assert rst_i in the cycle after a granted read.
  - Expect r_valid and r_data forced to 0.
  - After release, a read of the preloaded word still returns its original value.
